// File: rtl/fpu_pkg.sv
// Shared FPU definitions: precision-dependent widths, special-value encodings, operand classes.
package fpu_pkg;

   typedef enum logic [1:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_NAN} cls_e;

   function automatic int fpu_size(input int dbl);
      return (dbl != 0) ? 64 : 32;
   endfunction

   function automatic int fpu_exp(input int dbl);
      return (dbl != 0) ? 11 : 8;
   endfunction

   function automatic int fpu_mant(input int dbl);
      return (dbl != 0) ? 52 : 23;
   endfunction

   localparam logic [31:0] QNAN32 = 32'h7FC0_0000;
   localparam logic [63:0] QNAN64 = 64'h7FF8_0000_0000_0000;
   localparam logic [31:0] INF32  = 32'h7F80_0000;
   localparam logic [63:0] INF64  = 64'h7FF0_0000_0000_0000;

   // Returned right-aligned in 64 bits; callers truncate to their SIZE.
   function automatic logic [63:0] fpu_qnan(input int dbl);
      return (dbl != 0) ? QNAN64 : {32'h0, QNAN32};
   endfunction

   function automatic logic [63:0] fpu_inf(input int dbl);
      return (dbl != 0) ? INF64 : {32'h0, INF32};
   endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Parametrised leading-zero counter, purely combinational; all-zero input returns W.
module fpu_lzc #(
   parameter  int W  = 27,
   localparam int CW = $clog2(W + 1)
) (
   input  logic [W-1:0]  in_i,
   output logic [CW-1:0] cnt_o
);

   // Highest set bit is visited last and therefore wins.
   always_comb begin
      cnt_o = CW'(W);
      for (int i = 0; i < W; i++) begin
         if (in_i[i]) cnt_o = CW'(W - 1 - i);
      end
   end

endmodule

// File: rtl/fpu_add_pipe.sv
// Pipelined IEEE-754 add/sub (binary32/64), RNE, denormals flushed; FPU_ADD_FLAGS_EN adds a flags port.
// Capture register + 3 stages: result 3 cycles after accept, 1/cycle; whole pipe holds while result unaccepted.
module fpu_add_pipe
   import fpu_pkg::*;
#(
   parameter  int DOUBLE = 0,
   localparam int SIZE   = fpu_size(DOUBLE)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SIZE-1:0] a,
   input  logic [SIZE-1:0] b,
   input  logic            sub,
   output logic            out_valid,
   input  logic            out_ready,
`ifdef FPU_ADD_FLAGS_EN
   output logic [2:0]      flags,
`endif
   output logic [SIZE-1:0] result
);

   localparam int EXP  = fpu_exp(DOUBLE);
   localparam int MANT = fpu_mant(DOUBLE);
   localparam int FW   = MANT + 4;          // hidden, mantissa, guard, round, sticky
   localparam int EW   = EXP + 2;
   localparam int LZW  = $clog2(FW + 1);

   localparam logic [SIZE-1:0]      QNAN   = SIZE'(fpu_qnan(DOUBLE));
   localparam logic [SIZE-1:0]      INF    = SIZE'(fpu_inf(DOUBLE));
   localparam logic [EXP-1:0]       EMAX   = '1;
   localparam logic [EXP-1:0]       SHMAX  = EXP'(FW - 1);
   localparam logic signed [EW-1:0] E_ONE  = EW'(1);
   localparam logic signed [EW-1:0] E_ZERO = '0;
   localparam logic signed [EW-1:0] E_MAX  = $signed({2'b00, EMAX});

   function automatic cls_e classify(input logic [EXP-1:0] e, input logic [MANT-1:0] m);
      if (e == '0)        return CLS_ZERO;
      else if (e == EMAX) return (m == '0) ? CLS_INF : CLS_NAN;
      else                return CLS_NORM;
   endfunction

   logic            adv;
   logic            s0_vld_q, s0_sub_q;
   logic [SIZE-1:0] s0_a_q, s0_b_q;
   logic            s1_vld_q, s1_spec_q, s1_sign_q, s1_esub_q;
   logic [SIZE-1:0] s1_sres_q;
   logic [EXP-1:0]  s1_exp_q;
   logic [FW-1:0]   s1_x_q, s1_y_q;
   logic            s2_vld_q, s2_spec_q, s2_sign_q;
   logic [SIZE-1:0] s2_sres_q;
   logic [EXP-1:0]  s2_exp_q;
   logic [FW:0]     s2_sum_q;
   logic            s3_vld_q;
   logic [SIZE-1:0] s3_res_q;

   assign adv       = !s3_vld_q || out_ready;
   assign in_ready  = adv;
   assign out_valid = s3_vld_q;
   assign result    = s3_res_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         s0_vld_q <= 1'b0;
         s0_sub_q <= 1'b0;
         s0_a_q   <= '0;
         s0_b_q   <= '0;
      end else if (adv) begin
         s0_vld_q <= in_valid;
         s0_sub_q <= sub;
         s0_a_q   <= a;
         s0_b_q   <= b;
      end
   end

   // S1: classify, order by magnitude, align Y under X
   logic            sa, sb, sx, sy, swap, ysticky, spec1_d;
   logic [EXP-1:0]  ea, eb, ex, ey, d;
   logic [MANT-1:0] ma, mb, mx, my;
   cls_e            ca, cb, cy;
   logic [FW-2:0]   yraw, yfld;
   logic [SIZE-1:0] sres1_d;
`ifdef FPU_ADD_FLAGS_EN
   logic            inv1_d, s1_inv_q, s2_inv_q;
`endif

   always_comb begin
      sa   = s0_a_q[SIZE-1];
      sb   = s0_b_q[SIZE-1] ^ s0_sub_q;
      ea   = s0_a_q[SIZE-2 -: EXP];
      eb   = s0_b_q[SIZE-2 -: EXP];
      ca   = classify(ea, s0_a_q[MANT-1:0]);
      cb   = classify(eb, s0_b_q[MANT-1:0]);
      ma   = (ca == CLS_ZERO) ? '0 : s0_a_q[MANT-1:0];
      mb   = (cb == CLS_ZERO) ? '0 : s0_b_q[MANT-1:0];
      swap = {eb, mb} > {ea, ma};
      sx   = swap ? sb : sa;
      sy   = swap ? sa : sb;
      ex   = swap ? eb : ea;
      ey   = swap ? ea : eb;
      mx   = swap ? mb : ma;
      my   = swap ? ma : mb;
      cy   = swap ? ca : cb;
      d    = ex - ey;
      yraw = {cy == CLS_NORM, my, 2'b00};
      if (d >= SHMAX) begin
         yfld    = '0;
         ysticky = |yraw;
      end else begin
         yfld    = yraw >> d;
         ysticky = |(yraw & ~({(FW-1){1'b1}} << d));
      end

      spec1_d = 1'b1;
      sres1_d = '0;
`ifdef FPU_ADD_FLAGS_EN
      inv1_d  = 1'b0;
`endif
      if (ca == CLS_NAN || cb == CLS_NAN || (ca == CLS_INF && cb == CLS_INF && sa != sb)) begin
         sres1_d = QNAN;
`ifdef FPU_ADD_FLAGS_EN
         inv1_d  = 1'b1;
`endif
      end else if (ca == CLS_INF) begin
         sres1_d = {sa, INF[SIZE-2:0]};
      end else if (cb == CLS_INF) begin
         sres1_d = {sb, INF[SIZE-2:0]};
      end else if (ca == CLS_ZERO && cb == CLS_ZERO) begin
         sres1_d = {sa & sb, {(SIZE-1){1'b0}}};
      end else begin
         spec1_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld_q  <= 1'b0;
         s1_spec_q <= 1'b0;
         s1_sres_q <= '0;
         s1_sign_q <= 1'b0;
         s1_esub_q <= 1'b0;
         s1_exp_q  <= '0;
         s1_x_q    <= '0;
         s1_y_q    <= '0;
`ifdef FPU_ADD_FLAGS_EN
         s1_inv_q  <= 1'b0;
`endif
      end else if (adv) begin
         s1_vld_q  <= s0_vld_q;
         s1_spec_q <= spec1_d;
         s1_sres_q <= sres1_d;
         s1_sign_q <= sx;
         s1_esub_q <= sx ^ sy;
         s1_exp_q  <= ex;
         s1_x_q    <= {1'b1, mx, 3'b000};
         s1_y_q    <= {yfld, ysticky};
`ifdef FPU_ADD_FLAGS_EN
         s1_inv_q  <= inv1_d;
`endif
      end
   end

   // S2: magnitude add/subtract; X >= Y so the difference never goes negative
   logic [FW:0] sum2_d;
   assign sum2_d = s1_esub_q ? ({1'b0, s1_x_q} - {1'b0, s1_y_q})
                             : ({1'b0, s1_x_q} + {1'b0, s1_y_q});

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_vld_q  <= 1'b0;
         s2_spec_q <= 1'b0;
         s2_sres_q <= '0;
         s2_sign_q <= 1'b0;
         s2_exp_q  <= '0;
         s2_sum_q  <= '0;
`ifdef FPU_ADD_FLAGS_EN
         s2_inv_q  <= 1'b0;
`endif
      end else if (adv) begin
         s2_vld_q  <= s1_vld_q;
         s2_spec_q <= s1_spec_q;
         s2_sres_q <= s1_sres_q;
         s2_sign_q <= s1_sign_q;
         s2_exp_q  <= s1_exp_q;
         s2_sum_q  <= sum2_d;
`ifdef FPU_ADD_FLAGS_EN
         s2_inv_q  <= s1_inv_q;
`endif
      end
   end

   // S3: normalise, round to nearest even, pack
   logic [LZW-1:0]       lz;
   logic [FW-1:0]        nrm;
   logic signed [EW-1:0] e_nrm, e_rnd;
   logic [MANT+1:0]      m_rnd;
   logic                 g, r, s, lsb, up;
   logic [SIZE-1:0]      res3_d;
`ifdef FPU_ADD_FLAGS_EN
   logic [2:0]           flg3_d, s3_flg_q;
`endif

   fpu_lzc #(.W(FW)) u_lzc (
      .in_i  (s2_sum_q[FW-1:0]),
      .cnt_o (lz)
   );

   always_comb begin
      if (s2_sum_q[FW]) begin
         nrm   = {s2_sum_q[FW:2], s2_sum_q[1] | s2_sum_q[0]};
         e_nrm = $signed({2'b00, s2_exp_q}) + E_ONE;
      end else begin
         nrm   = s2_sum_q[FW-1:0] << lz;
         e_nrm = $signed({2'b00, s2_exp_q}) - $signed({{(EW-LZW){1'b0}}, lz});
      end
      lsb   = nrm[3];
      g     = nrm[2];
      r     = nrm[1];
      s     = nrm[0];
      up    = g & (r | s | lsb);
      m_rnd = {1'b0, nrm[FW-1:3]} + {{(MANT+1){1'b0}}, up};
      e_rnd = e_nrm + $signed({{(EW-1){1'b0}}, m_rnd[MANT+1]});

      res3_d = '0;
`ifdef FPU_ADD_FLAGS_EN
      flg3_d = 3'b000;
`endif
      if (s2_spec_q) begin
         res3_d = s2_sres_q;
`ifdef FPU_ADD_FLAGS_EN
         flg3_d = {s2_inv_q, 2'b00};
`endif
      end else if (s2_sum_q == '0) begin
         res3_d = '0;
      end else if (e_rnd >= E_MAX) begin
         res3_d = {s2_sign_q, INF[SIZE-2:0]};
`ifdef FPU_ADD_FLAGS_EN
         flg3_d = 3'b011;
`endif
      end else if (e_rnd <= E_ZERO) begin
         res3_d = {s2_sign_q, {(SIZE-1){1'b0}}};
`ifdef FPU_ADD_FLAGS_EN
         flg3_d = 3'b001;
`endif
      end else begin
         res3_d = {s2_sign_q, e_rnd[EXP-1:0], m_rnd[MANT-1:0]};
`ifdef FPU_ADD_FLAGS_EN
         flg3_d = {2'b00, g | r | s};
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s3_vld_q <= 1'b0;
         s3_res_q <= '0;
`ifdef FPU_ADD_FLAGS_EN
         s3_flg_q <= 3'b000;
`endif
      end else if (adv) begin
         s3_vld_q <= s2_vld_q;
         s3_res_q <= res3_d;
`ifdef FPU_ADD_FLAGS_EN
         s3_flg_q <= flg3_d;
`endif
      end
   end

`ifdef FPU_ADD_FLAGS_EN
   assign flags = s3_flg_q;
`endif

endmodule

// File: tb/tb_fpu_add_pipe.sv
// Directed bench for fpu_add_pipe: binary32 and binary64 instances, vector table plus stall/reset sequences.
`timescale 1ns/1ps
module tb_fpu_add_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        iv32, ir32, ov32, or32, sub32;
   logic [31:0] a32, b32, r32;
   logic        iv64, ir64, ov64, or64, sub64;
   logic [63:0] a64, b64, r64;
`ifdef FPU_ADD_FLAGS_EN
   logic [2:0]  fl32, fl64;
`endif

   fpu_add_pipe #(.DOUBLE(0)) u_dut32 (
      .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32), .sub(sub32),
      .out_valid(ov32), .out_ready(or32),
`ifdef FPU_ADD_FLAGS_EN
      .flags(fl32),
`endif
      .result(r32)
   );

   fpu_add_pipe #(.DOUBLE(1)) u_dut64 (
      .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(ir64), .a(a64), .b(b64), .sub(sub64),
      .out_valid(ov64), .out_ready(or64),
`ifdef FPU_ADD_FLAGS_EN
      .flags(fl64),
`endif
      .result(r64)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sub;
      logic [31:0] res;
      logic [2:0]  flg;
      logic        fchk;
   } vec32_t;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        sub;
      logic [63:0] res;
   } vec64_t;

   task automatic apply32(input logic [31:0] ta, input logic [31:0] tb, input logic ts,
                          output logic [31:0] tr, output int lat);
      int w;
      @(negedge clk);
      a32 = ta; b32 = tb; sub32 = ts; iv32 = 1'b1;
      #1;
      w = 0;
      while (!ir32 && w < 20) begin @(negedge clk); w++; end
      @(negedge clk);
      iv32 = 1'b0;
      #1;
      lat = 0;
      while (!ov32 && lat < 20) begin @(negedge clk); #1; lat++; end
      tr = r32;
   endtask

   task automatic apply64(input logic [63:0] ta, input logic [63:0] tb, input logic ts,
                          output logic [63:0] tr, output int lat);
      int w;
      @(negedge clk);
      a64 = ta; b64 = tb; sub64 = ts; iv64 = 1'b1;
      #1;
      w = 0;
      while (!ir64 && w < 20) begin @(negedge clk); w++; end
      @(negedge clk);
      iv64 = 1'b0;
      #1;
      lat = 0;
      while (!ov64 && lat < 20) begin @(negedge clk); #1; lat++; end
      tr = r64;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec32_t      v32 [20];
      vec64_t      v64 [5];
      logic [31:0] kf [8];
      logic [31:0] k2 [8];
      logic [31:0] res;
      logic [63:0] res64;
      logic [31:0] held_res;
      logic        held, saw_drop, bad_ov;
      int          lat, tx, rx;

      v32[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 1'b1};
      v32[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b000, 1'b1};
      v32[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, 1'b1};
      v32[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, 1'b1};
      v32[4]  = '{32'h3F800000, 32'h34000000, 1'b0, 32'h3F800001, 3'b000, 1'b1};
      v32[5]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 3'b001, 1'b1};
      v32[6]  = '{32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b001, 1'b1};
      v32[7]  = '{32'h3F7FFFFF, 32'h33000000, 1'b0, 32'h3F800000, 3'b001, 1'b1};
      v32[8]  = '{32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b100, 1'b1};
      v32[9]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b011, 1'b1};
      v32[10] = '{32'h00000001, 32'h00000000, 1'b0, 32'h00000000, 3'b000, 1'b0};
      v32[11] = '{32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 3'b000, 1'b1};
      v32[12] = '{32'h3F800000, 32'hC0000000, 1'b0, 32'hBF800000, 3'b000, 1'b1};
      v32[13] = '{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 3'b100, 1'b1};
      v32[14] = '{32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 3'b000, 1'b1};
      v32[15] = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3'b100, 1'b1};
      v32[16] = '{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 3'b001, 1'b1};
      v32[17] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 3'b000, 1'b1};
      v32[18] = '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 3'b000, 1'b1};
      v32[19] = '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 3'b000, 1'b1};

      v64[0] = '{64'h3FF0000000000000, 64'hBFF0000000000000, 1'b0, 64'h0000000000000000};
      v64[1] = '{64'h3FF0000000000000, 64'h4000000000000000, 1'b0, 64'h4008000000000000};
      v64[2] = '{64'h3FF0000000000000, 64'h3CA0000000000000, 1'b0, 64'h3FF0000000000000};
      v64[3] = '{64'h7FF0000000000000, 64'hFFF0000000000000, 1'b0, 64'h7FF8000000000000};
      v64[4] = '{64'h4000000000000000, 64'h3FF0000000000000, 1'b1, 64'h3FF0000000000000};

      kf = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
      k2 = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000,
             32'h41200000, 32'h41400000, 32'h41600000, 32'h41800000};

      rst = 1'b1;
      iv32 = 1'b0; a32 = '0; b32 = '0; sub32 = 1'b0; or32 = 1'b1;
      iv64 = 1'b0; a64 = '0; b64 = '0; sub64 = 1'b0; or64 = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("reset_out_valid", 64'(ov32), 64'd0);
      check("reset_result", 64'(r32), 64'd0);
      check("reset_in_ready", 64'(ir32), 64'd1);
      check("reset_out_valid64", 64'(ov64), 64'd0);

      for (int i = 0; i < 20; i++) begin
         apply32(v32[i].a, v32[i].b, v32[i].sub, res, lat);
         check($sformatf("v32_%0d_result", i), 64'(res), 64'(v32[i].res));
         check($sformatf("v32_%0d_latency", i), 64'(lat), 64'd3);
`ifdef FPU_ADD_FLAGS_EN
         if (v32[i].fchk) check($sformatf("v32_%0d_flags", i), 64'(fl32), 64'(v32[i].flg));
`endif
      end

      for (int i = 0; i < 5; i++) begin
         apply64(v64[i].a, v64[i].b, v64[i].sub, res64, lat);
         check($sformatf("v64_%0d_result", i), res64, v64[i].res);
         check($sformatf("v64_%0d_latency", i), 64'(lat), 64'd3);
      end

      // Back-to-back stream with out_ready low for cycles 4..8
      tx = 0; rx = 0; held = 1'b0; saw_drop = 1'b0; held_res = '0;
      for (int cyc = 1; cyc <= 60 && rx < 8; cyc++) begin
         @(negedge clk);
         or32 = !(cyc >= 4 && cyc <= 8);
         if (tx < 8) begin
            iv32 = 1'b1; a32 = kf[tx]; b32 = kf[tx]; sub32 = 1'b0;
         end else begin
            iv32 = 1'b0;
         end
         #1;
         if (held) begin
            check("stall_result_hold", 64'(r32), 64'(held_res));
            check("stall_valid_hold", 64'(ov32), 64'd1);
         end
         if (!ir32) saw_drop = 1'b1;
         if (ov32 && or32) begin
            check($sformatf("stream_%0d", rx), 64'(r32), 64'(k2[rx]));
            rx++;
         end
         held     = ov32 && !or32;
         held_res = r32;
         if (iv32 && ir32) tx++;
      end
      iv32 = 1'b0; or32 = 1'b1;
      check("stream_in_ready_dropped", 64'(saw_drop), 64'd1);
      check("stream_sent", 64'(tx), 64'd8);
      check("stream_received", 64'(rx), 64'd8);
      bad_ov = 1'b0;
      repeat (5) begin @(negedge clk); #1; if (ov32) bad_ov = 1'b1; end
      check("stream_no_extra", 64'(bad_ov), 64'd0);

      // Reset with two operations in flight
      @(negedge clk);
      iv32 = 1'b1; a32 = 32'h3F800000; b32 = 32'h3F800000; sub32 = 1'b0;
      @(negedge clk);
      a32 = 32'h40000000; b32 = 32'h40000000;
      @(negedge clk);
      iv32 = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_in_ready", 64'(ir32), 64'd1);
      check("midrst_out_valid", 64'(ov32), 64'd0);
      check("midrst_result", 64'(r32), 64'd0);
      bad_ov = 1'b0;
      repeat (6) begin @(negedge clk); #1; if (ov32) bad_ov = 1'b1; end
      check("midrst_no_output", 64'(bad_ov), 64'd0);
      apply32(32'h3F800000, 32'h3F800000, 1'b0, res, lat);
      check("post_rst_result", 64'(res), 64'h40000000);
      check("post_rst_latency", 64'(lat), 64'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
